// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU op sequencer: FSM states, instruction layout
// and ALU opcodes so issuers can encode instructions symbolically.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int INSTR_W   = 17;
  localparam int NO_WB_BIT = 16;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 8;
  localparam int RS1_MSB   = 7;
  localparam int RS1_LSB   = 4;
  localparam int RS2_MSB   = 3;
  localparam int RS2_LSB   = 0;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  function automatic logic [INSTR_W-1:0] enc_instr(input logic [3:0] op,
                                                   input logic [3:0] rd,
                                                   input logic [3:0] rs1,
                                                   input logic [3:0] rs2,
                                                   input logic       no_wb);
    return {no_wb, op, rd, rs1, rs2};
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: accepts one ALU instruction, drives the register-file/ALU
// datapath, optionally writes back, then hands the result to the issuer.
//
// state | meaning
// IDLE  | ready for an instruction
// EXEC  | read ports and ALU control driven, result captured at end of cycle
// WB    | one-cycle register write-back of the captured result
// RESP  | result offered to the issuer until out_ready
module alu_op_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W+3*REG_AW:0]    in_instr,
  output logic [OP_W-1:0]           alu_control,
  output logic [REG_AW-1:0]         read_reg1,
  output logic [REG_AW-1:0]         read_reg2,
  output logic [REG_AW-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_enable,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_result,
  output logic                      out_zero,
  output logic [CNT_W-1:0]          retired
);

  localparam int NB = OP_W + 3*REG_AW;

  state_t              state_q, state_d;
  logic                no_wb_q;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   result_q;
  logic                zero_q;
  logic [CNT_W-1:0]    retired_q;
  logic                accept, resp_done;

  assign accept    = in_valid && in_ready;
  assign resp_done = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = no_wb_q ? RESP : WB;
      WB:   state_d = RESP;
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      no_wb_q   <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      if (accept) begin
        no_wb_q <= in_instr[NB];
        op_q    <= in_instr[NB-1:3*REG_AW];
        rd_q    <= in_instr[3*REG_AW-1:2*REG_AW];
        rs1_q   <= in_instr[2*REG_AW-1:REG_AW];
        rs2_q   <= in_instr[REG_AW-1:0];
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (resp_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Gating with reset keeps the register file from committing a write-back
  // on the very edge where reset aborts the operation.
  assign write_enable = (state_q == WB) && !reset;
  assign in_ready     = (state_q == IDLE) && !reset;
  assign out_valid    = (state_q == RESP);

  assign alu_control = op_q;
  assign read_reg1   = rs1_q;
  assign read_reg2   = rs2_q;
  assign write_reg   = rd_q;
  assign write_data  = result_q;
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file + ALU;
// a second instance with a 3-bit retired counter exercises counter wrap.
module tb_alu_op_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [16:0] in_instr;
  logic        out_ready;

  logic        in_ready, write_enable, out_valid, out_zero, alu_zero;
  logic [3:0]  alu_control, read_reg1, read_reg2, write_reg;
  logic [31:0] write_data, alu_result, out_result;
  logic [15:0] retired;

  logic        w_in_ready, w_write_enable, w_out_valid, w_out_zero;
  logic [3:0]  w_alu_control, w_read_reg1, w_read_reg2, w_write_reg;
  logic [31:0] w_write_data, w_out_result;
  logic [2:0]  w_retired;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_control(alu_control), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .write_reg(write_reg), .write_data(write_data),
    .write_enable(write_enable), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .retired(retired)
  );

  alu_op_sequencer #(.CNT_W(3)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .alu_control(w_alu_control), .read_reg1(w_read_reg1),
    .read_reg2(w_read_reg2), .write_reg(w_write_reg), .write_data(w_write_data),
    .write_enable(w_write_enable), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
    .out_zero(w_out_zero), .retired(w_retired)
  );

  // Behavioural datapath: register file with a preload port, combinational ALU.
  logic [31:0] rf [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] op_a, op_b;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (write_enable) rf[write_reg] <= write_data;
  end

  always_comb begin
    op_a = rf[read_reg1];
    op_b = rf[read_reg2];
    case (alu_control)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_SLT: alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_ret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake_and_check();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret = exp_ret + 16'd1;
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("retired_wrap", 32'(w_retired), 32'(exp_ret[2:0]));
    chk("out_valid_after_resp", 32'(out_valid), 32'd0);
    chk("in_ready_after_resp", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [16:0] instr, input logic wb, input logic [3:0] wreg,
                        input logic [31:0] res, input logic z);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
    in_instr = 17'($urandom);
    chk("in_ready_exec", 32'(in_ready), 32'd0);
    chk("we_exec", 32'(write_enable), 32'd0);
    tick();
    if (wb) begin
      chk("we_wb", 32'(write_enable), 32'd1);
      chk("write_reg", 32'(write_reg), 32'(wreg));
      chk("write_data", write_data, res);
      chk("out_valid_wb", 32'(out_valid), 32'd0);
      tick();
    end
    chk("we_resp", 32'(write_enable), 32'd0);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_result", out_result, res);
    chk("out_zero", 32'(out_zero), 32'(z));
    chk("in_ready_resp", 32'(in_ready), 32'd0);
    handshake_and_check();
  endtask

  typedef struct {
    logic [16:0] instr;
    logic        wb;
    logic [3:0]  wreg;
    logic [31:0] result;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Preloads: R1=5 R2=7 R5=-1 R6=1, all others 0.
    vecs[0] = '{enc_instr(ALU_ADD, 4'd3,  4'd1, 4'd2, 1'b0), 1'b1, 4'd3,  32'd12,        1'b0};
    vecs[1] = '{enc_instr(ALU_SUB, 4'd0,  4'd1, 4'd1, 1'b1), 1'b0, 4'd0,  32'd0,         1'b1};
    vecs[2] = '{enc_instr(ALU_ADD, 4'd4,  4'd3, 4'd2, 1'b0), 1'b1, 4'd4,  32'd19,        1'b0};
    vecs[3] = '{enc_instr(ALU_ADD, 4'd7,  4'd5, 4'd6, 1'b0), 1'b1, 4'd7,  32'd0,         1'b1};
    vecs[4] = '{enc_instr(ALU_AND, 4'd8,  4'd4, 4'd5, 1'b0), 1'b1, 4'd8,  32'd19,        1'b0};
    vecs[5] = '{enc_instr(ALU_OR,  4'd9,  4'd1, 4'd2, 1'b1), 1'b0, 4'd9,  32'd7,         1'b0};
    vecs[6] = '{enc_instr(ALU_XOR, 4'd10, 4'd3, 4'd4, 1'b0), 1'b1, 4'd10, 32'd31,        1'b0};
    vecs[7] = '{enc_instr(ALU_SLT, 4'd11, 4'd5, 4'd6, 1'b0), 1'b1, 4'd11, 32'd1,         1'b0};
    vecs[8] = '{enc_instr(ALU_SUB, 4'd12, 4'd2, 4'd1, 1'b0), 1'b1, 4'd12, 32'd2,         1'b0};
    vecs[9] = '{enc_instr(ALU_SUB, 4'd13, 4'd6, 4'd5, 1'b1), 1'b0, 4'd13, 32'd2,         1'b0};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    exp_ret = 16'd0;

    tick();
    pl_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pl_addr = 4'(i);
      case (i)
        1: pl_data = 32'd5;
        2: pl_data = 32'd7;
        5: pl_data = 32'hFFFF_FFFF;
        6: pl_data = 32'd1;
        default: pl_data = 32'd0;
      endcase
      tick();
    end
    pl_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // Back-to-back issue; vector 2 reads R3 written by vector 0 (RAW).
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].instr, vecs[i].wb, vecs[i].wreg, vecs[i].result, vecs[i].zero);
    chk("rf_r3", rf[3], 32'd12);
    chk("rf_r4", rf[4], 32'd19);
    chk("rf_r9_untouched", rf[9], 32'd0);

    // Result backpressure with the next instruction held on in_valid.
    chk("bp_in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = enc_instr(ALU_ADD, 4'd14, 4'd1, 4'd2, 1'b0);
    tick();
    in_instr = enc_instr(ALU_OR, 4'd15, 4'd1, 4'd6, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_result", out_result, 32'd12);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_retired", 32'(retired), 32'(exp_ret));
      tick();
    end
    handshake_and_check();
    tick();
    in_valid = 1'b0;
    chk("held_accepted", 32'(in_ready), 32'd0);
    tick();
    chk("held_out_valid", 32'(out_valid), 32'd1);
    chk("held_result", out_result, 32'd5);
    handshake_and_check();
    chk("rf_r14", rf[14], 32'd12);

    // Reset while in WB: the write-back must be abandoned.
    in_valid = 1'b1;
    in_instr = enc_instr(ALU_ADD, 4'd3, 4'd1, 4'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_we_wb", 32'(write_enable), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_we_reset", 32'(write_enable), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    exp_ret = 16'd0;
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_retired", 32'(retired), 32'd0);
    chk("mid_wrap_retired", 32'(w_retired), 32'd0);
    chk("mid_rf_r3", rf[3], 32'd12);

    run_op(enc_instr(ALU_SUB, 4'd2, 4'd2, 4'd1, 1'b1), 1'b0, 4'd2, 32'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
